// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: FSM state encoding, default bus widths and timeout counter width helper
package apb_arb_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 8;
  function automatic int cnt_w(int timeout);
    return $clog2(timeout);
  endfunction
endpackage

// File: rtl/apb_rr_pick.sv
// apb_rr_pick: combinational round-robin pick; req, ptr -> one-hot win, index idx, any request
module apb_rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [1:0]         idx,
  output logic               any
);
  int d, best;
  always_comb begin
    idx = '0;
    d = 0;
    best = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = i >= int'(ptr) ? i - int'(ptr) : i + NUM_REQ - int'(ptr);
      if (req[i] && d < best) begin
        best = d;
        idx = 2'(i);
      end
    end
  end
  assign any = |req;
  assign win = any ? NUM_REQ'(1) << idx : '0;
endmodule

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: round-robin sharing of the apb_top command port among NUM_REQ requesters; ports pclk/preset, req* in, gnt/done/err/rdata out, APB command out, apb_read_data/m_done in
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [NUM_REQ-1:0]        err,
  output logic [DATA_W-1:0]         rdata,
  output logic                      transfer,
  output logic                      read_write,
  output logic [ADDR_W-1:0]         apb_write_paddr,
  output logic [ADDR_W-1:0]         apb_read_paddr,
  output logic [DATA_W-1:0]         apb_write_data,
  input  logic [DATA_W-1:0]         apb_read_data,
  input  logic                      m_done
);
  localparam int CW = cnt_w(TIMEOUT);
  logic [1:0] state, ptr, owner, w, nxt;
  logic [NUM_REQ-1:0] win;
  logic any, wr;
  logic [ADDR_W-1:0] addr;
  logic [CW-1:0] cnt;
  apb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (.req(req), .ptr(ptr), .win(win), .idx(w), .any(any));
  assign wr = req_write[w];
  assign addr = req_addr[w*ADDR_W +: ADDR_W];
  assign nxt = owner == 2'(NUM_REQ - 1) ? 2'd0 : owner + 2'd1;
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      cnt <= '0;
      gnt <= '0;
      done <= '0;
      err <= '0;
      rdata <= '0;
      transfer <= 1'b0;
      read_write <= 1'b0;
      apb_write_paddr <= '0;
      apb_read_paddr <= '0;
      apb_write_data <= '0;
    end else if (state == IDLE) begin
      if (any) begin
        state <= BUSY;
        owner <= w;
        cnt <= '0;
        gnt <= win;
        transfer <= 1'b1;
        read_write <= ~wr;
        apb_write_paddr <= wr ? addr : '0;
        apb_read_paddr <= wr ? '0 : addr;
        apb_write_data <= wr ? req_wdata[w*DATA_W +: DATA_W] : '0;
      end
    end else if (state == BUSY) begin
      cnt <= cnt + 1'b1;
      // m_done is checked first so it beats a timeout landing in the same cycle
      if (m_done || cnt == CW'(TIMEOUT - 1)) begin
        state <= RESP;
        transfer <= 1'b0;
        ptr <= nxt;
        done <= m_done ? gnt : '0;
        err <= m_done ? '0 : gnt;
        rdata <= m_done && read_write ? apb_read_data : rdata;
      end
    end else begin
      state <= IDLE;
      gnt <= '0;
      done <= '0;
      err <= '0;
    end
  end
endmodule

// File: tb/tb_apb_rr_arbiter.sv
// tb_apb_rr_arbiter: directed self-checking bench for apb_rr_arbiter
module tb_apb_rr_arbiter;
  logic pclk = 1'b0, preset = 1'b1;
  logic [1:0] req = '0, req_write = '0, gnt, done, err;
  logic [17:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [7:0] rdata, apb_write_data, apb_read_data = '0;
  logic transfer, read_write, m_done = 1'b0;
  logic [8:0] apb_write_paddr, apb_read_paddr;
  int checks = 0, errors = 0;
  apb_rr_arbiter dut (
    .pclk(pclk), .preset(preset), .req(req), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .transfer(transfer), .read_write(read_write), .apb_write_paddr(apb_write_paddr),
    .apb_read_paddr(apb_read_paddr), .apb_write_data(apb_write_data),
    .apb_read_data(apb_read_data), .m_done(m_done)
  );
  always #5 pclk = ~pclk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    repeat (2) @(negedge pclk);
    chk("rst_out", {gnt, done, err, rdata, transfer, read_write}, 0);
    chk("rst_addr", {apb_write_paddr, apb_read_paddr, apb_write_data}, 0);
    preset = 1'b0;
    // single write from requester 0
    req = 2'b01; req_write = 2'b01; req_addr[8:0] = 9'h066; req_wdata[7:0] = 8'hAA;
    @(negedge pclk);
    chk("w_xfer", {transfer, read_write, gnt}, {1'b1, 1'b0, 2'b01});
    chk("w_paddr", apb_write_paddr, 9'h066);
    chk("w_data", apb_write_data, 8'hAA);
    chk("w_rpaddr", apb_read_paddr, 0);
    req = 2'b00;
    @(negedge pclk);
    chk("w_hold", {transfer, gnt, done}, {1'b1, 2'b01, 2'b00});
    m_done = 1'b1;
    @(negedge pclk);
    m_done = 1'b0;
    chk("w_done", {done, err, transfer, gnt}, {2'b01, 2'b00, 1'b0, 2'b01});
    @(negedge pclk);
    chk("w_after", {done, gnt, transfer}, 0);
    // read back from requester 1
    req = 2'b10; req_write = 2'b00; req_addr[17:9] = 9'h066;
    @(negedge pclk);
    chk("r_xfer", {transfer, read_write, gnt}, {1'b1, 1'b1, 2'b10});
    chk("r_paddr", apb_read_paddr, 9'h066);
    chk("r_wpaddr", {apb_write_paddr, apb_write_data}, 0);
    req = 2'b00; apb_read_data = 8'hAA; m_done = 1'b1;
    @(negedge pclk);
    m_done = 1'b0; apb_read_data = 8'h00;
    chk("r_done", {done, err}, {2'b10, 2'b00});
    chk("r_rdata", rdata, 8'hAA);
    @(negedge pclk);
    m_done = 1'b1;
    @(negedge pclk);
    m_done = 1'b0;
    chk("idle_mdone", {done, err, transfer, gnt}, 0);
    chk("rdata_hold", rdata, 8'hAA);
    // contention: both requesters held high, grants alternate
    req = 2'b11; req_write = 2'b11; req_addr = {9'h123, 9'h045}; req_wdata = {8'h22, 8'h11};
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      chk("c_gnt", {transfer, gnt}, {1'b1, i % 2 == 0 ? 2'b01 : 2'b10});
      chk("c_addr", apb_write_paddr, i % 2 == 0 ? 9'h045 : 9'h123);
      m_done = 1'b1;
      @(negedge pclk);
      m_done = 1'b0;
      if (i == 3) req = 2'b00;
      chk("c_done", {done, transfer}, {i % 2 == 0 ? 2'b01 : 2'b10, 1'b0});
      @(negedge pclk);
      chk("c_gap", transfer, 0);
    end
    // timeout on requester 0, then requester 1 is next
    req = 2'b01; req_write = 2'b01;
    @(negedge pclk);
    chk("t_xfer", {transfer, gnt}, {1'b1, 2'b01});
    req = 2'b00;
    repeat (15) @(negedge pclk);
    chk("t_16th", {transfer, err, done}, {1'b1, 2'b00, 2'b00});
    req = 2'b11;
    @(negedge pclk);
    chk("t_err", {err, done, transfer}, {2'b01, 2'b00, 1'b0});
    @(negedge pclk);
    chk("t_idle", {err, transfer}, 0);
    @(negedge pclk);
    chk("t_next", {transfer, gnt}, {1'b1, 2'b10});
    // requester drops mid-BUSY; transaction still completes
    req = 2'b00;
    repeat (2) @(negedge pclk);
    m_done = 1'b1;
    @(negedge pclk);
    m_done = 1'b0;
    chk("drop_done", {done, err}, {2'b10, 2'b00});
    @(negedge pclk);
    // m_done coinciding with the last timeout cycle
    req = 2'b01;
    @(negedge pclk);
    req = 2'b00;
    repeat (15) @(negedge pclk);
    chk("tie_busy", {transfer, err}, {1'b1, 2'b00});
    m_done = 1'b1;
    @(negedge pclk);
    m_done = 1'b0;
    chk("tie_done", {done, err}, {2'b01, 2'b00});
    @(negedge pclk);
    // asynchronous reset while BUSY; pointer returns to 0
    req = 2'b10; req_write = 2'b10;
    @(negedge pclk);
    chk("pre_rst", {transfer, gnt}, {1'b1, 2'b10});
    #2 preset = 1'b1;
    #1;
    chk("arst_out", {gnt, done, err, rdata, transfer, read_write}, 0);
    chk("arst_addr", {apb_write_paddr, apb_read_paddr, apb_write_data}, 0);
    @(negedge pclk);
    preset = 1'b0; req = 2'b11;
    @(negedge pclk);
    chk("post_rst", {transfer, gnt}, {1'b1, 2'b01});
    req = 2'b00; m_done = 1'b1;
    @(negedge pclk);
    m_done = 1'b0;
    chk("post_done", done, 2'b01);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
